// File: rtl/boot_memory_if.sv
// ---------------------------------------------------------------------------
// boot_memory_if
//
// Purpose:
//   Bundles the CPU-side bus and the image-loader boot port of boot_memory.
//   The signals keep the datapath's original names so that existing glue
//   logic can be connected without renaming.
//
// Signals (direction as seen by the memory, i.e. the slave modport):
//   Address    in   ADDR_WIDTH  CPU word address
//   DataIn     in   DATA_WIDTH  CPU store data
//   MemWrite   in   1           CPU write strobe, 0 = read
//   MemVal     out  DATA_WIDTH  registered read data
//   Ready      out  1           memory is serving CPU traffic
//   AddrError  out  1           registered out-of-range flag
//   BootValid  in   1           loader presents an image word
//   BootData   in   DATA_WIDTH  image word
//   BootLast   in   1           marks the final image word
//   BootReady  out  1           memory accepts image words
//   BootCount  out  ADDR_WIDTH  image words accepted so far
//
// Modports:
//   master - CPU / loader side
//   slave  - memory side
// ---------------------------------------------------------------------------
interface boot_memory_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);

    // CPU bus
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] MemVal;
    logic                  Ready;
    logic                  AddrError;

    // Boot (image loader) port
    logic                  BootValid;
    logic [DATA_WIDTH-1:0] BootData;
    logic                  BootLast;
    logic                  BootReady;
    logic [ADDR_WIDTH-1:0] BootCount;

    modport master (
        output Address, DataIn, MemWrite,
        output BootValid, BootData, BootLast,
        input  MemVal, Ready, AddrError,
        input  BootReady, BootCount
    );

    modport slave (
        input  Address, DataIn, MemWrite,
        input  BootValid, BootData, BootLast,
        output MemVal, Ready, AddrError,
        output BootReady, BootCount
    );

endinterface

// File: rtl/boot_memory.sv
// ---------------------------------------------------------------------------
// boot_memory
//
// Purpose:
//   Single-port synchronous RAM with a built-in power-on sequencer.
//   After reset the sequencer walks through three phases:
//     CLEAR - writes CLEAR_VALUE into every word, one word per cycle
//             (exactly DEPTH cycles).
//     BOOT  - accepts a streamed program image over a valid/ready port,
//             storing word n at address n.
//     RUN   - serves CPU loads, stores and fetches until the next reset.
//
// Parameters:
//   DATA_WIDTH    width of every memory word and data port
//   ADDR_WIDTH    width of the CPU Address port and of BootCount
//   DEPTH         number of words, legal addresses 0..DEPTH-1
//   CLEAR_VALUE   word written everywhere during CLEAR
//   WRITE_THROUGH 0: MemVal holds on a write cycle, 1: MemVal takes DataIn
//
// Ports:
//   clock   in   system clock, everything updates on the rising edge
//   reset   in   synchronous active-high, restarts the sequencer at CLEAR
//   bus     slave modport of boot_memory_if (CPU bus + boot port)
// ---------------------------------------------------------------------------
module boot_memory #(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    DEPTH         = 512,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
    parameter bit                    WRITE_THROUGH = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    boot_memory_if.slave  bus
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened by one bit so that DEPTH == 2**ADDR_WIDTH still compares
    // correctly against the full unsigned Address.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]      LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_COUNT = ADDR_WIDTH'(DEPTH - 1);

    // Elaboration-time sanity checks on the geometry.
    if (DEPTH < 1) begin : g_depth_too_small
        $error("boot_memory: DEPTH must be at least 1");
    end
    if (longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_depth_too_big
        $error("boot_memory: DEPTH must not exceed 2**ADDR_WIDTH");
    end

    // -----------------------------------------------------------------------
    // Sequencer state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [PTR_W-1:0]      r_clr_ptr;
    logic [ADDR_WIDTH-1:0] r_boot_count;
    logic [DATA_WIDTH-1:0] r_mem_val;
    logic                  r_addr_error;

    logic                  w_ready;
    logic                  w_boot_ready;
    logic                  w_boot_fire;
    logic                  w_boot_done;
    logic                  w_in_range;
    logic [PTR_W-1:0]      w_cpu_idx;

    logic                  w_mem_we;
    logic [PTR_W-1:0]      w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // -----------------------------------------------------------------------
    // Handshake and address decode
    // -----------------------------------------------------------------------
    // A boot word transfers only while BootReady is high, so BootValid in
    // CLEAR or RUN (and BootLast without BootValid) never has an effect.
    assign w_boot_fire = w_boot_ready && bus.BootValid;

    // The transfer at the last address ends BOOT even without BootLast so
    // that an over-long image can never run past the top of memory.
    assign w_boot_done = w_boot_fire &&
                         (bus.BootLast || (r_boot_count == LAST_COUNT));

    // Unsigned compare over the full Address: high addresses never alias.
    assign w_in_range  = ({1'b0, bus.Address} < DEPTH_EXT);
    assign w_cpu_idx   = bus.Address[PTR_W-1:0];

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values of the others; blocking (=) here
    // would make the result depend on statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default on entry so that no path
    // leaves it unassigned; a missing default infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_CLEAR: begin
                if (r_clr_ptr == LAST_PTR) begin
                    w_next_state = ST_BOOT;
                end
            end
            ST_BOOT: begin
                if (w_boot_done) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_next_state = ST_RUN;
            end
            default: begin
                w_next_state = ST_CLEAR;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_ready      = 1'b0;
        w_boot_ready = 1'b0;
        unique case (r_state)
            ST_BOOT: w_boot_ready = 1'b1;
            ST_RUN:  w_ready      = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Single memory write port, shared by the three phases
    // -----------------------------------------------------------------------
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = CLEAR_VALUE;
        unique case (r_state)
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_ptr;
                w_mem_wdata = CLEAR_VALUE;
            end
            ST_BOOT: begin
                w_mem_we    = w_boot_fire;
                w_mem_addr  = r_boot_count[PTR_W-1:0];
                w_mem_wdata = bus.BootData;
            end
            ST_RUN: begin
                // Out-of-range stores are dropped, never truncated.
                w_mem_we    = bus.MemWrite && w_in_range;
                w_mem_addr  = w_cpu_idx;
                w_mem_wdata = bus.DataIn;
            end
            default: ;
        endcase
    end

    // NOTE: the array has no reset branch; a reset loop over DEPTH words
    // would prevent RAM inference. The CLEAR phase initialises it instead.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_ptr    <= '0;
            r_boot_count <= '0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + PTR_W'(1);
            end
            // Only advances in BOOT, so it is frozen once RUN is reached.
            if (w_boot_fire) begin
                r_boot_count <= r_boot_count + ADDR_WIDTH'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered read data and address-error flag
    // -----------------------------------------------------------------------
    // Both hold their value outside RUN. In RUN every cycle is an access, so
    // AddrError is re-evaluated each cycle and drops on the next in-range one.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_val    <= '0;
            r_addr_error <= 1'b0;
        end else if (w_ready) begin
            if (!w_in_range) begin
                r_mem_val    <= '0;
                r_addr_error <= 1'b1;
            end else begin
                r_addr_error <= 1'b0;
                if (!bus.MemWrite) begin
                    r_mem_val <= r_mem[w_cpu_idx];
                end else if (WRITE_THROUGH) begin
                    r_mem_val <= bus.DataIn;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign bus.MemVal    = r_mem_val;
    assign bus.AddrError = r_addr_error;
    assign bus.Ready     = w_ready;
    assign bus.BootReady = w_boot_ready;
    assign bus.BootCount = r_boot_count;

endmodule

// File: tb/tb_boot_memory.sv
// ---------------------------------------------------------------------------
// tb_boot_memory
//
// Two boot_memory instances with DEPTH = 8 share one stimulus stream:
//   dut_a: WRITE_THROUGH = 0, CLEAR_VALUE = 16'h0000
//   dut_b: WRITE_THROUGH = 1, CLEAR_VALUE = 16'hC1EA
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// that same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_boot_memory;

    localparam int          DW   = 16;
    localparam int          AW   = 16;
    localparam int          DEP  = 8;
    localparam logic [15:0] CV_A = 16'h0000;
    localparam logic [15:0] CV_B = 16'hC1EA;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AW-1:0] address    = '0;
    logic [DW-1:0] data_in    = '0;
    logic          mem_write  = 1'b0;
    logic          boot_valid = 1'b0;
    logic [DW-1:0] boot_data  = '0;
    logic          boot_last  = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    boot_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    boot_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.Address   = address;
    assign bus_a.DataIn    = data_in;
    assign bus_a.MemWrite  = mem_write;
    assign bus_a.BootValid = boot_valid;
    assign bus_a.BootData  = boot_data;
    assign bus_a.BootLast  = boot_last;

    assign bus_b.Address   = address;
    assign bus_b.DataIn    = data_in;
    assign bus_b.MemWrite  = mem_write;
    assign bus_b.BootValid = boot_valid;
    assign bus_b.BootData  = boot_data;
    assign bus_b.BootLast  = boot_last;

    boot_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP),
        .CLEAR_VALUE(CV_A), .WRITE_THROUGH(1'b0)
    ) dut_a (
        .clock(clk),
        .reset(rst),
        .bus  (bus_a.slave)
    );

    boot_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP),
        .CLEAR_VALUE(CV_B), .WRITE_THROUGH(1'b1)
    ) dut_b (
        .clock(clk),
        .reset(rst),
        .bus  (bus_b.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held for two edges: every output at its reset value.
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({bus_a.Ready, bus_a.BootReady, bus_b.Ready, bus_b.BootReady} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready_bootready got=%b exp=%b",
                     {bus_a.Ready, bus_a.BootReady, bus_b.Ready, bus_b.BootReady}, 4'b0000);
        end
        total++;
        if ({bus_a.MemVal, bus_b.MemVal} !== 32'h0) begin
            bad++;
            $display("FAIL reset_memval got=%h exp=%h", {bus_a.MemVal, bus_b.MemVal}, 32'h0);
        end
        total++;
        if ({bus_a.AddrError, bus_b.AddrError, bus_a.BootCount, bus_b.BootCount} !== 34'h0) begin
            bad++;
            $display("FAIL reset_adderr_count got=%h exp=%h",
                     {bus_a.AddrError, bus_b.AddrError, bus_a.BootCount, bus_b.BootCount}, 34'h0);
        end
        rst = 1'b0;
    endtask

    // CLEAR lasts exactly 8 edges; boot and CPU inputs are ignored throughout.
    task automatic test_clear(input logic with_noise);
        boot_valid = with_noise;
        boot_last  = with_noise;
        boot_data  = 16'hBAD0;
        address    = 16'd3;
        mem_write  = with_noise;
        data_in    = 16'hFFFF;
        for (int i = 1; i < DEP; i++) begin
            step();
            total++;
            if ({bus_a.Ready, bus_a.BootReady, bus_b.Ready, bus_b.BootReady} !== 4'b0000) begin
                bad++;
                $display("FAIL clear_cycle%0d got=%b exp=%b", i,
                         {bus_a.Ready, bus_a.BootReady, bus_b.Ready, bus_b.BootReady}, 4'b0000);
            end
        end
        step();
        total++;
        if ({bus_a.Ready, bus_a.BootReady, bus_b.Ready, bus_b.BootReady} !== 4'b0101) begin
            bad++;
            $display("FAIL clear_to_boot got=%b exp=%b",
                     {bus_a.Ready, bus_a.BootReady, bus_b.Ready, bus_b.BootReady}, 4'b0101);
        end
        total++;
        if ({bus_a.BootCount, bus_b.BootCount} !== 32'h0) begin
            bad++;
            $display("FAIL clear_bootcount got=%h exp=%h", {bus_a.BootCount, bus_b.BootCount}, 32'h0);
        end
        boot_valid = 1'b0;
        boot_last  = 1'b0;
        mem_write  = 1'b0;
    endtask

    // Three image words with a BootValid gap (BootLast alone in the gap).
    task automatic test_boot();
        logic [15:0] words [3];
        words[0] = 16'h0008;
        words[1] = 16'h0814;
        words[2] = 16'h8014;

        boot_valid = 1'b1; boot_data = words[0]; boot_last = 1'b0;
        step();
        total++;
        if ({bus_a.BootCount, bus_b.BootCount} !== {16'd1, 16'd1}) begin
            bad++;
            $display("FAIL boot_count1 got=%h exp=%h", {bus_a.BootCount, bus_b.BootCount}, {16'd1, 16'd1});
        end

        boot_valid = 1'b0; boot_data = 16'hDEAD; boot_last = 1'b1;
        step();
        total++;
        if ({bus_a.BootCount, bus_b.BootCount, bus_a.BootReady, bus_a.Ready} !== {16'd1, 16'd1, 2'b10}) begin
            bad++;
            $display("FAIL boot_gap got=%h exp=%h",
                     {bus_a.BootCount, bus_b.BootCount, bus_a.BootReady, bus_a.Ready}, {16'd1, 16'd1, 2'b10});
        end

        boot_valid = 1'b1; boot_data = words[1]; boot_last = 1'b0;
        step();
        total++;
        if ({bus_a.BootCount, bus_b.BootCount} !== {16'd2, 16'd2}) begin
            bad++;
            $display("FAIL boot_count2 got=%h exp=%h", {bus_a.BootCount, bus_b.BootCount}, {16'd2, 16'd2});
        end

        boot_data = words[2]; boot_last = 1'b1;
        step();
        total++;
        if ({bus_a.BootCount, bus_b.BootCount} !== {16'd3, 16'd3}) begin
            bad++;
            $display("FAIL boot_count3 got=%h exp=%h", {bus_a.BootCount, bus_b.BootCount}, {16'd3, 16'd3});
        end
        total++;
        if ({bus_a.Ready, bus_a.BootReady, bus_b.Ready, bus_b.BootReady} !== 4'b1010) begin
            bad++;
            $display("FAIL boot_to_run got=%b exp=%b",
                     {bus_a.Ready, bus_a.BootReady, bus_b.Ready, bus_b.BootReady}, 4'b1010);
        end
        boot_valid = 1'b0;
        boot_last  = 1'b0;
    endtask

    // Reads every address; addresses below n_boot hold image words.
    task automatic test_read_all(input int n_boot, input logic [15:0] w0,
                                 input logic [15:0] w1, input logic [15:0] w2,
                                 input logic [15:0] base);
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        mem_write = 1'b0;
        for (int a = 0; a < DEP; a++) begin
            address = 16'(a);
            step();
            if (base != 16'h0) begin
                exp_a = base + 16'(a);
                exp_b = exp_a;
            end else if (a < n_boot) begin
                exp_a = (a == 0) ? w0 : (a == 1) ? w1 : w2;
                exp_b = exp_a;
            end else begin
                exp_a = CV_A;
                exp_b = CV_B;
            end
            total++;
            if ({bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError} !== {exp_a, exp_b, 2'b00}) begin
                bad++;
                $display("FAIL read_addr%0d got=%h exp=%h", a,
                         {bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError}, {exp_a, exp_b, 2'b00});
            end
        end
    endtask

    // Write to address 5: MemVal holds (dut_a) or takes DataIn (dut_b).
    task automatic test_write_through();
        address = 16'd5; mem_write = 1'b1; data_in = 16'h1234;
        step();
        total++;
        if ({bus_a.MemVal, bus_b.MemVal} !== {CV_A, 16'h1234}) begin
            bad++;
            $display("FAIL write_cycle_memval got=%h exp=%h", {bus_a.MemVal, bus_b.MemVal}, {CV_A, 16'h1234});
        end
        mem_write = 1'b0;
        step();
        total++;
        if ({bus_a.MemVal, bus_b.MemVal} !== {16'h1234, 16'h1234}) begin
            bad++;
            $display("FAIL read_after_write got=%h exp=%h", {bus_a.MemVal, bus_b.MemVal}, {16'h1234, 16'h1234});
        end
    endtask

    // Out-of-range accesses, with boot inputs active in RUN (ignored).
    task automatic test_addr_error();
        boot_valid = 1'b1; boot_last = 1'b1; boot_data = 16'hEEEE;

        address = 16'd8; mem_write = 1'b1; data_in = 16'hDEAD;
        step();
        total++;
        if ({bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError} !== {32'h0, 2'b11}) begin
            bad++;
            $display("FAIL oor_write8 got=%h exp=%h",
                     {bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError}, {32'h0, 2'b11});
        end

        address = 16'd7; mem_write = 1'b0;
        step();
        total++;
        if ({bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError} !== {CV_A, CV_B, 2'b00}) begin
            bad++;
            $display("FAIL addr7_untouched got=%h exp=%h",
                     {bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError}, {CV_A, CV_B, 2'b00});
        end

        address = 16'hFFFF; mem_write = 1'b0;
        step();
        total++;
        if ({bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError} !== {32'h0, 2'b11}) begin
            bad++;
            $display("FAIL oor_read_ffff got=%h exp=%h",
                     {bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError}, {32'h0, 2'b11});
        end

        address = 16'h0108; mem_write = 1'b1; data_in = 16'hBEEF;
        step();
        total++;
        if ({bus_a.AddrError, bus_b.AddrError} !== 2'b11) begin
            bad++;
            $display("FAIL oor_write_0108 got=%b exp=%b", {bus_a.AddrError, bus_b.AddrError}, 2'b11);
        end

        // Neither 8 nor 0x0108 may alias onto address 0.
        address = 16'd0; mem_write = 1'b0;
        step();
        total++;
        if ({bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError} !== {16'h0008, 16'h0008, 2'b00}) begin
            bad++;
            $display("FAIL no_alias_addr0 got=%h exp=%h",
                     {bus_a.MemVal, bus_b.MemVal, bus_a.AddrError, bus_b.AddrError}, {16'h0008, 16'h0008, 2'b00});
        end
        total++;
        if ({bus_a.BootCount, bus_b.BootCount, bus_a.BootReady, bus_b.BootReady} !== {16'd3, 16'd3, 2'b00}) begin
            bad++;
            $display("FAIL run_boot_frozen got=%h exp=%h",
                     {bus_a.BootCount, bus_b.BootCount, bus_a.BootReady, bus_b.BootReady}, {16'd3, 16'd3, 2'b00});
        end
        boot_valid = 1'b0; boot_last = 1'b0;
    endtask

    // BootLast never asserted: 8 words then RUN, the 9th is refused.
    task automatic test_overflow();
        rst = 1'b1;
        step();
        rst = 1'b0;
        test_clear(1'b0);
        boot_valid = 1'b1; boot_last = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            boot_data = 16'h0100 + 16'(i);
            step();
            total++;
            if ({bus_a.BootCount, bus_b.BootCount, bus_a.Ready, bus_b.Ready} !==
                {16'(i + 1), 16'(i + 1), (i == DEP - 1), (i == DEP - 1)}) begin
                bad++;
                $display("FAIL overflow_word%0d got=%h exp=%h", i,
                         {bus_a.BootCount, bus_b.BootCount, bus_a.Ready, bus_b.Ready},
                         {16'(i + 1), 16'(i + 1), (i == DEP - 1), (i == DEP - 1)});
            end
        end
        boot_data = 16'h01FF;
        step();
        total++;
        if ({bus_a.BootCount, bus_b.BootCount, bus_a.BootReady, bus_b.BootReady} !== {16'd8, 16'd8, 2'b00}) begin
            bad++;
            $display("FAIL overflow_ninth got=%h exp=%h",
                     {bus_a.BootCount, bus_b.BootCount, bus_a.BootReady, bus_b.BootReady}, {16'd8, 16'd8, 2'b00});
        end
        boot_valid = 1'b0;
        test_read_all(DEP, 16'h0, 16'h0, 16'h0, 16'h0100);
    endtask

    // Reset after two boot words: CLEAR restarts and wipes them.
    task automatic test_reset_mid_boot();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({bus_a.MemVal, bus_b.MemVal, bus_a.Ready, bus_b.Ready} !== {32'h0, 2'b00}) begin
            bad++;
            $display("FAIL rerun_reset_memval got=%h exp=%h",
                     {bus_a.MemVal, bus_b.MemVal, bus_a.Ready, bus_b.Ready}, {32'h0, 2'b00});
        end
        test_clear(1'b0);
        boot_valid = 1'b1; boot_last = 1'b0; boot_data = 16'h1111;
        step();
        boot_data = 16'h2222;
        step();
        total++;
        if ({bus_a.BootCount, bus_b.BootCount} !== {16'd2, 16'd2}) begin
            bad++;
            $display("FAIL midboot_count2 got=%h exp=%h", {bus_a.BootCount, bus_b.BootCount}, {16'd2, 16'd2});
        end
        boot_valid = 1'b0;
        rst = 1'b1;
        step();
        total++;
        if ({bus_a.BootCount, bus_b.BootCount, bus_a.BootReady, bus_b.BootReady} !== 34'h0) begin
            bad++;
            $display("FAIL midboot_reset got=%h exp=%h",
                     {bus_a.BootCount, bus_b.BootCount, bus_a.BootReady, bus_b.BootReady}, 34'h0);
        end
        rst = 1'b0;
        test_clear(1'b1);
        boot_valid = 1'b1; boot_last = 1'b1; boot_data = 16'h0ABC;
        step();
        total++;
        if ({bus_a.BootCount, bus_b.BootCount, bus_a.Ready, bus_b.Ready} !== {16'd1, 16'd1, 2'b11}) begin
            bad++;
            $display("FAIL midboot_reboot got=%h exp=%h",
                     {bus_a.BootCount, bus_b.BootCount, bus_a.Ready, bus_b.Ready}, {16'd1, 16'd1, 2'b11});
        end
        boot_valid = 1'b0; boot_last = 1'b0;
        test_read_all(1, 16'h0ABC, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_clear(1'b1);
        test_boot();
        test_read_all(3, 16'h0008, 16'h0814, 16'h8014, 16'h0);
        test_write_through();
        test_addr_error();
        test_overflow();
        test_reset_mid_boot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
